store_writer: RTL and testbench

- Store-side counterpart of the load-data formatter in the memory stage.
- Accepts a store (address, raw register data, size) from the MEM stage, aligns the data into the 64-bit bus lane and generates byte strobes.
- Issues the write on the data bus with a valid/addr_ok/data_ok handshake and holds the pipeline until the write completes.
- Detects misaligned stores and reports them without touching the bus.

---
 rtl/store_writer.sv | 125 ++++++++++++
 tb/tb_store_writer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_writer.sv
// Store-side write formatter: aligns a MEM-stage store into the 64-bit bus lane,
// builds byte strobes, runs the bus handshake and flags misaligned stores.
module store_writer (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [63:0] st_addr,
    input  logic [63:0] st_data,
    input  logic [1:0]  st_msize,
    input  logic        flush,
    output logic        st_done,
    output logic        st_misalign,
    output logic        dreq_valid,
    output logic [63:0] dreq_addr,
    output logic [1:0]  dreq_size,
    output logic [7:0]  dreq_strobe,
    output logic [63:0] dreq_data,
    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] MSIZE1 = 2'd0;
    localparam logic [1:0] MSIZE2 = 2'd1;
    localparam logic [1:0] MSIZE4 = 2'd2;
    localparam logic [1:0] MSIZE8 = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state;
    logic        flushed;
    logic [2:0]  off;
    logic [7:0]  mask;
    logic        misalign;
    logic        accept;

    // Handshakes: a store transfers on st_valid & st_ready & !flush; the bus
    // request is held with all fields stable until dresp_data_ok is sampled high.
    assign st_ready  = (state == IDLE);
    assign accept    = st_valid & st_ready & ~flush;
    assign off       = st_addr[2:0];
    assign dbg_state = state;

    always_comb begin
        mask     = 8'h01;
        misalign = 1'b0;
        case (st_msize)
            MSIZE1: begin mask = 8'h01; misalign = 1'b0; end
            MSIZE2: begin mask = 8'h03; misalign = st_addr[0]; end
            MSIZE4: begin mask = 8'h0F; misalign = |st_addr[1:0]; end
            MSIZE8: begin mask = 8'hFF; misalign = |st_addr[2:0]; end
            default: begin mask = 8'h01; misalign = 1'b0; end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            flushed     <= 1'b0;
            st_done     <= 1'b0;
            st_misalign <= 1'b0;
            dreq_valid  <= 1'b0;
            dreq_addr   <= 64'd0;
            dreq_size   <= MSIZE1;
            dreq_strobe <= 8'h00;
            dreq_data   <= 64'd0;
        end else begin
            st_done     <= 1'b0;
            st_misalign <= 1'b0;
            case (state)
                IDLE: begin
                    flushed <= 1'b0;
                    if (accept) begin
                        if (misalign) begin
                            st_misalign <= 1'b1;
                        end else begin
                            dreq_addr   <= st_addr;
                            dreq_size   <= st_msize;
                            dreq_strobe <= mask << off;
                            dreq_data   <= st_data << {off, 3'b000};
                            dreq_valid  <= 1'b1;
                            state       <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    // Only an uncommitted request (no addr_ok yet) can be abandoned.
                    if (flush && !dresp_addr_ok) begin
                        dreq_valid <= 1'b0;
                        state      <= IDLE;
                    end else if (dresp_data_ok) begin
                        dreq_valid <= 1'b0;
                        st_done    <= ~(flush | flushed);
                        flushed    <= flushed | flush;
                        state      <= RESP;
                    end else if (dresp_addr_ok) begin
                        flushed <= flush;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (dresp_data_ok) begin
                        dreq_valid <= 1'b0;
                        st_done    <= ~(flush | flushed);
                        state      <= RESP;
                    end else if (flush) begin
                        flushed <= 1'b1;
                    end
                end
                RESP: begin
                    flushed <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_writer.sv
// Self-checking bench for store_writer: directed cases plus randomized stores,
// compared against a byte-level reference model of lane alignment and handshake.
module tb_store_writer;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [63:0] st_addr;
    logic [63:0] st_data;
    logic [1:0]  st_msize;
    logic        flush;
    logic        st_done;
    logic        st_misalign;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [1:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_mis = 0;
    int done_seen = 0;
    int mis_seen = 0;
    int done_exp = 0;
    int mis_exp = 0;
    logic [63:0] exp_q[$];

    store_writer dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_msize(st_msize),
        .flush(flush), .st_done(st_done), .st_misalign(st_misalign),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset) begin
            if (st_done) done_seen++;
            if (st_misalign) mis_seen++;
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference model: byte-lane view of the store
    function automatic int nbytes(input logic [1:0] size);
        return 1 << size;
    endfunction

    function automatic logic [7:0] model_strobe(input logic [63:0] addr, input logic [1:0] size);
        logic [7:0] s;
        int o;
        s = 8'h00;
        o = int'(addr[2:0]);
        for (int i = 0; i < 8; i++)
            if (i >= o && i < o + nbytes(size)) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] model_data(input logic [63:0] addr, input logic [63:0] data);
        logic [63:0] r;
        int o;
        r = 64'd0;
        o = int'(addr[2:0]);
        for (int i = 0; i < 8; i++)
            if (i >= o) r[8*i +: 8] = data[8*(i-o) +: 8];
        return r;
    endfunction

    function automatic bit model_misalign(input logic [63:0] addr, input logic [1:0] size);
        return (addr % 64'(nbytes(size))) != 64'd0;
    endfunction

    // driver: one store; addr_ok in wait cycle a, data_ok d cycles later,
    // flush in wait cycle f (-1 = none)
    task automatic do_store(input logic [63:0] addr, input logic [63:0] data,
                            input logic [1:0] size, input int a, input int d, input int f);
        logic [63:0] held;
        logic [7:0]  strb;
        bit          want_done;
        check("ready_before_accept", 64'(st_ready), 64'd1);
        st_valid = 1'b1;
        st_addr  = addr;
        st_data  = data;
        st_msize = size;
        tick();
        st_valid = 1'b0;
        st_addr  = $urandom();
        st_data  = {$urandom(), $urandom()};
        if (model_misalign(addr, size)) begin
            mis_exp++;
            check("misalign_pulse", 64'(st_misalign), 64'd1);
            check("misalign_no_valid", 64'(dreq_valid), 64'd0);
            check("misalign_no_done", 64'(st_done), 64'd0);
            tick();
            check("misalign_one_cycle", 64'(st_misalign), 64'd0);
            check("misalign_still_no_valid", 64'(dreq_valid), 64'd0);
            return;
        end
        exp_q.push_back(model_data(addr, data));
        strb = model_strobe(addr, size);
        held = 64'd0;
        want_done = (f < 0);
        for (int k = 0; k <= a + d; k++) begin
            check("valid_held", 64'(dreq_valid), 64'd1);
            if (k == 0) held = exp_q.pop_front();
            check("dreq_data", dreq_data, held);
            check("dreq_strobe", 64'(dreq_strobe), 64'(strb));
            check("dreq_addr", dreq_addr, addr);
            check("dreq_size", 64'(dreq_size), 64'(size));
            check("no_early_done", 64'(st_done), 64'd0);
            dresp_addr_ok = (k == a);
            dresp_data_ok = (k == a + d);
            flush         = (k == f);
            tick();
            dresp_addr_ok = 1'b0;
            dresp_data_ok = 1'b0;
            flush         = 1'b0;
            if (k == f && f < a) begin
                check("flush_drop_valid", 64'(dreq_valid), 64'd0);
                check("flush_drop_no_done", 64'(st_done), 64'd0);
                check("flush_drop_ready", 64'(st_ready), 64'd1);
                return;
            end
        end
        if (want_done) done_exp++;
        check("resp_valid_low", 64'(dreq_valid), 64'd0);
        check("resp_done", 64'(st_done), 64'(want_done));
        check("resp_not_ready", 64'(st_ready), 64'd0);
        tick();
        check("done_one_cycle", 64'(st_done), 64'd0);
        check("ready_after_resp", 64'(st_ready), 64'd1);
    endtask

    initial begin
        reset = 1'b0;
        st_valid = 1'b0;
        st_addr = 64'd0;
        st_data = 64'd0;
        st_msize = 2'd0;
        flush = 1'b0;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        repeat (3) tick();
        check("rst_valid", 64'(dreq_valid), 64'd0);
        check("rst_done", 64'(st_done), 64'd0);
        check("rst_misalign", 64'(st_misalign), 64'd0);
        check("rst_addr", dreq_addr, 64'd0);
        check("rst_data", dreq_data, 64'd0);
        check("rst_strobe", 64'(dreq_strobe), 64'd0);
        check("rst_size", 64'(dreq_size), 64'd0);
        #2 reset = 1'b1;
        tick();
        check("rst_ready", 64'(st_ready), 64'd1);

        // directed cases
        do_store(64'h1003, 64'hAB, 2'd0, 0, 0, -1);
        do_store(64'h2004, 64'hDEADBEEF, 2'd2, 2, 3, -1);
        do_store(64'h3001, 64'h1234, 2'd1, 0, 0, -1);
        do_store(64'h3004, 64'h55, 2'd3, 0, 0, -1);
        do_store(64'h4000, 64'h0123456789ABCDEF, 2'd3, 1, 2, 2);
        do_store(64'h5002, 64'h77, 2'd0, 1, 0, 0);
        do_store(64'h5005, 64'h99, 2'd0, 0, 1, -1);
        do_store(64'h6006, 64'hBEEF, 2'd1, 1, 1, 1);

        // flush in IDLE blocks acceptance (even of a misaligned store)
        st_valid = 1'b1; flush = 1'b1; st_addr = 64'h7001; st_msize = 2'd1;
        tick();
        st_valid = 1'b0; flush = 1'b0;
        check("idle_flush_no_valid", 64'(dreq_valid), 64'd0);
        check("idle_flush_no_misalign", 64'(st_misalign), 64'd0);
        check("idle_flush_ready", 64'(st_ready), 64'd1);

        // reset asserted while in DATA
        st_valid = 1'b1; st_addr = 64'h8000; st_data = 64'h11; st_msize = 2'd3;
        tick();
        st_valid = 1'b0; dresp_addr_ok = 1'b1;
        tick();
        dresp_addr_ok = 1'b0;
        check("in_data_valid", 64'(dreq_valid), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_valid", 64'(dreq_valid), 64'd0);
        check("async_rst_done", 64'(st_done), 64'd0);
        check("async_rst_misalign", 64'(st_misalign), 64'd0);
        check("async_rst_strobe", 64'(dreq_strobe), 64'd0);
        #3 reset = 1'b1;
        tick();
        check("ready_after_rst", 64'(st_ready), 64'd1);

        // randomized stores
        for (int n = 0; n < 60; n++) begin
            logic [63:0] ra;
            logic [63:0] rd;
            logic [1:0]  rs;
            int a, d, f;
            ra = {32'd0, $urandom()};
            rd = {$urandom(), $urandom()};
            rs = 2'($urandom_range(0, 3));
            a  = $urandom_range(0, 3);
            d  = $urandom_range(0, 3);
            f  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, a + d) : -1;
            do_store(ra, rd, rs, a, d, f);
        end

        repeat (2) tick();
        check("done_count", 64'(done_seen), 64'(done_exp));
        check("misalign_count", 64'(mis_seen), 64'(mis_exp));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
